mux16_rr_sched: RTL and testbench
=================================

Name: mux16_rr_sched

Overview:
Round-robin scheduler that shares one 16:1 single-bit mux between 16 requesters. It picks one requester, drives the mux select lines, and holds the grant for a bounded number of cycles. While the grant is held it registers the selected data bit with a valid strobe. It sits in front of the 16x1 mux datapath and owns its select_lines; data flows from the requesters to data_out.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 (4-bit select). Other values are unsupported.
- HOLD_MAX, 4, maximum consecutive SERVE cycles per grant; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req  input  16  request vector; bit i is requester i
- data_inputs  input  16  per-requester data bit, same map as the mux data inputs
- select_lines  output  4  mux select; index of the current or last grantee
- grant  output  16  one-hot grant; all zero when no grant is held
- data_out  output  1  registered data_inputs[select_lines] during SERVE
- data_valid  output  1  high for each cycle data_out holds a served bit
- busy  output  1  high in SERVE and RELEASE

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values:
  - select_lines=0, grant=0, data_out=0, data_valid=0, busy=0.
  - state=IDLE, last_grant=15, so the first pick starts the search at index 0.
  - hold_cnt=0.
- States:
  - IDLE: if req!=0, pick the first set bit searching upward from last_grant+1, wrapping 15->0. Register select_lines, set grant to one-hot(pick), hold_cnt=0, go to SERVE. If req==0, stay in IDLE.
  - SERVE:
    - Each cycle: data_out <= data_inputs[select_lines], data_valid <= 1, hold_cnt++.
    - Exit when req[select_lines]==0 (sampled this cycle) or hold_cnt==HOLD_MAX-1. On exit: grant<=0, last_grant<=select_lines, go to RELEASE.
    - If the request drops, data_valid is 0 in that same exit cycle; the dropped cycle is not served.
  - RELEASE: one mandatory dead cycle. data_valid=0, grant=0, select_lines unchanged. Go to IDLE.
- Latency:
  - A request seen in IDLE at cycle t gives grant/select_lines valid at t+1.
  - The first data_valid is at t+2. data_out reflects data_inputs sampled at t+1.
  - Back-to-back grants are spaced HOLD_MAX+2 cycles apart when all requests are held.
- Fairness: the granted index never repeats while any other index is requesting.
- A sole requester is regranted after RELEASE+IDLE; the wrap search returns itself.
- Simultaneous events:
  - A request rising during SERVE/RELEASE is considered only in the next IDLE.
  - A request from the grantee dropping on the same cycle hold_cnt hits its limit is treated as a drop: data_valid=0.
- rst asserted mid-SERVE: all outputs return to reset values on the next edge, last_grant=15, and the in-flight bit is discarded.
- busy = (state==SERVE || state==RELEASE).

Optional Feature:
- Macro: MUX16_RR_SCHED_LOCK_EN.
- Defined: adds input lock (1 bit). While lock=1 in SERVE, the HOLD_MAX limit is ignored and only a request drop ends the grant. lock is ignored in IDLE and RELEASE.
- Undefined: no lock port; HOLD_MAX always applies.

Decomposition:
- Package mux16_rr_pkg holds:
  - the state enum {IDLE, SERVE, RELEASE};
  - SEL_W=4, N_REQ=16;
  - the hold_cnt width constant (8).
- Sub-module rr_pick16: combinational rotate/priority encoder.
  - Inputs: req[15:0], last[3:0].
  - Outputs: idx[3:0], any.
  - Instantiated once and testable in isolation.

Test Plan:
- Single request: rst 2 cycles, then req=16'h0001 held, data_inputs[0]=1. Expect grant=16'h0001 and select_lines=0 at t+1; data_valid high for 4 cycles with data_out=1; 1 RELEASE cycle; regrant of index 0.
- All requesting: req=16'hFFFF held. Grants cycle 0,1,2,...,15,0, each 4 valid cycles with 6-cycle spacing. No index repeats before all 16 are served.
- Wrap-around: last_grant=14 after serving 14; req=16'h0009. Next grant is index 0, then 3, then 0.
- Early drop: req[5] granted; deassert it after 2 valid cycles. Expect data_valid 2 cycles then 0, grant=0 next edge, RELEASE, then the next requester.
- Reset mid-grant: assert rst during SERVE of index 7. Next edge: grant=0, data_valid=0, select_lines=0. With req=16'hFFFF afterwards, the first grant is index 0.
- LOCK_EN build: lock=1 with req[3] held 10 cycles. Expect 10 consecutive valid cycles, then release on the req drop.

Source files
------------

// File: rtl/mux16_rr_pkg.sv
// Shared types and constants for the 16-requester round-robin mux scheduler.
package mux16_rr_pkg;

  localparam int unsigned N_REQ  = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
    onehot16 = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Rotating priority encoder: first set request bit searching upward from last+1, wrapping.
module rr_pick16
  import mux16_rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] w_cand;
  logic             w_found;

  // Offset N_REQ wraps back onto last itself, so a sole requester re-picks itself.
  always_comb begin
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = last + SEL_W'(k);
      if (!w_found && req[w_cand]) begin
        idx     = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler owning a shared 16:1 mux; holds each grant up to HOLD_MAX cycles.
// Optional MUX16_RR_SCHED_LOCK_EN adds a lock input that suspends the hold limit.
module mux16_rr_sched
  import mux16_rr_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MUX16_RR_SCHED_LOCK_EN
  input  logic             lock,
`endif
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_inputs,
  output logic [SEL_W-1:0] select_lines,
  output logic [N_REQ-1:0] grant,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy
);

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt;
  logic               r_dout, w_dout_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic [SEL_W-1:0]   r_last, w_last_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic [SEL_W-1:0]   w_pick;
  logic               w_any;
  logic               w_limit;

  rr_pick16 u_pick (
    .req  (req),
    .last (r_last),
    .idx  (w_pick),
    .any  (w_any)
  );

  // >= rather than == so a lock released late still ends the grant at once.
`ifdef MUX16_RR_SCHED_LOCK_EN
  assign w_limit = !lock && (r_hold >= HOLD_W'(HOLD_MAX - 1));
`else
  assign w_limit = (r_hold >= HOLD_W'(HOLD_MAX - 1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = SERVE;
          w_sel_nxt   = w_pick;
          w_grant_nxt = onehot16(w_pick);
          w_hold_nxt  = '0;
        end
      end
      SERVE: begin
        // A dropped request ends the grant without serving that cycle.
        if (!req[r_sel]) begin
          w_state_nxt = RELEASE;
          w_grant_nxt = '0;
          w_last_nxt  = r_sel;
        end else begin
          w_dout_nxt  = data_inputs[r_sel];
          w_valid_nxt = 1'b1;
          w_hold_nxt  = (r_hold == '1) ? r_hold : r_hold + HOLD_W'(1);
          if (w_limit) begin
            w_state_nxt = RELEASE;
            w_grant_nxt = '0;
            w_last_nxt  = r_sel;
          end
        end
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == SERVE) || (w_state_nxt == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_grant <= '0;
      r_dout  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= SEL_W'(N_REQ - 1);
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign select_lines = r_sel;
  assign grant        = r_grant;
  assign data_out     = r_dout;
  assign data_valid   = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Table-driven, scoreboarded bench for mux16_rr_sched (HOLD_MAX = 4).
module tb_mux16_rr_sched;

  typedef struct {
    logic        rst;
    logic        lk;
    logic [15:0] req;
    logic [15:0] din;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;
    logic        dout;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;
    logic        dout;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] data_inputs;
  logic [3:0]  select_lines;
  logic [15:0] grant;
  logic        data_out;
  logic        data_valid;
  logic        busy;
`ifdef MUX16_RR_SCHED_LOCK_EN
  logic        lock;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;
  vec_t tbl[$];
  exp_t sb[$];

  mux16_rr_sched #(.HOLD_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef MUX16_RR_SCHED_LOCK_EN
    .lock         (lock),
`endif
    .req          (req),
    .data_inputs  (data_inputs),
    .select_lines (select_lines),
    .grant        (grant),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at step %0d", step_no);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step_no, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic lk, input logic [15:0] rq,
                              input logic [15:0] dn, input logic [15:0] g, input logic [3:0] s,
                              input logic v, input logic d, input logic b);
    tbl.push_back('{r, lk, rq, dn, g, s, v, d, b});
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst         = v.rst;
    req         = v.req;
    data_inputs = v.din;
`ifdef MUX16_RR_SCHED_LOCK_EN
    lock        = v.lk;
`endif
    sb.push_back('{v.grant, v.sel, v.valid, v.dout, v.busy});
    @(posedge clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", step_no);
    end else begin
      e = sb.pop_front();
      chk("grant", grant, e.grant);
      chk("select_lines", 16'(select_lines), 16'(e.sel));
      chk("data_valid", 16'(data_valid), 16'(e.valid));
      chk("busy", 16'(busy), 16'(e.busy));
      if (e.valid) chk("data_out", 16'(data_out), 16'(e.dout));
    end
  endtask

  task automatic run(input logic r, input logic lk, input logic [15:0] rq, input logic [15:0] dn,
                     input logic [15:0] g, input logic [3:0] s, input logic v, input logic d,
                     input logic b);
    vec_t x;
    x = '{r, lk, rq, dn, g, s, v, d, b};
    apply(x);
  endtask

  initial begin
    logic [15:0] dpat;
    logic [3:0]  ix;
    rst = 1'b1;
    req = '0;
    data_inputs = '0;
`ifdef MUX16_RR_SCHED_LOCK_EN
    lock = 1'b0;
`endif

    // Single requester: grant, 4 served cycles, release, regrant, then a data change and a drop.
    add(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 0);
    add(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 0);
    add(0, 0, 16'h0001, 16'h0001, 16'h0001, 4'd0, 0, 0, 1);
    add(0, 0, 16'h0001, 16'h0001, 16'h0001, 4'd0, 1, 1, 1);
    add(0, 0, 16'h0001, 16'h0001, 16'h0001, 4'd0, 1, 1, 1);
    add(0, 0, 16'h0001, 16'h0001, 16'h0001, 4'd0, 1, 1, 1);
    add(0, 0, 16'h0001, 16'h0001, 16'h0000, 4'd0, 1, 1, 1);
    add(0, 0, 16'h0001, 16'h0001, 16'h0000, 4'd0, 0, 0, 0);
    add(0, 0, 16'h0001, 16'h0001, 16'h0001, 4'd0, 0, 0, 1);
    add(0, 0, 16'h0001, 16'h0001, 16'h0001, 4'd0, 1, 1, 1);
    add(0, 0, 16'h0001, 16'h0000, 16'h0001, 4'd0, 1, 0, 1);
    add(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 1);
    add(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 0);
    add(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 0);

    // Wrap-around: serve 14 (dropped at once), then req 0 and 3 -> grants 0, 3, 0.
    add(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 0);
    add(0, 0, 16'h4000, 16'h0008, 16'h4000, 4'd14, 0, 0, 1);
    add(0, 0, 16'h0009, 16'h0008, 16'h0000, 4'd14, 0, 0, 1);
    add(0, 0, 16'h0009, 16'h0008, 16'h0000, 4'd14, 0, 0, 0);
    add(0, 0, 16'h0009, 16'h0008, 16'h0001, 4'd0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 16'h0009, 16'h0008, 16'h0001, 4'd0, 1, 0, 1);
    add(0, 0, 16'h0009, 16'h0008, 16'h0000, 4'd0, 1, 0, 1);
    add(0, 0, 16'h0009, 16'h0008, 16'h0000, 4'd0, 0, 0, 0);
    add(0, 0, 16'h0009, 16'h0008, 16'h0008, 4'd3, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 16'h0009, 16'h0008, 16'h0008, 4'd3, 1, 1, 1);
    add(0, 0, 16'h0009, 16'h0008, 16'h0000, 4'd3, 1, 1, 1);
    add(0, 0, 16'h0009, 16'h0008, 16'h0000, 4'd3, 0, 0, 0);
    add(0, 0, 16'h0009, 16'h0008, 16'h0001, 4'd0, 0, 0, 1);

    // Early drop of 5 after 2 served cycles, next requester 8, then drop exactly at the limit.
    add(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 0);
    add(0, 0, 16'h0020, 16'h0020, 16'h0020, 4'd5, 0, 0, 1);
    add(0, 0, 16'h0020, 16'h0020, 16'h0020, 4'd5, 1, 1, 1);
    add(0, 0, 16'h0020, 16'h0020, 16'h0020, 4'd5, 1, 1, 1);
    add(0, 0, 16'h0100, 16'h0020, 16'h0000, 4'd5, 0, 0, 1);
    add(0, 0, 16'h0100, 16'h0020, 16'h0000, 4'd5, 0, 0, 0);
    add(0, 0, 16'h0100, 16'h0020, 16'h0100, 4'd8, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 16'h0100, 16'h0020, 16'h0100, 4'd8, 1, 0, 1);
    add(0, 0, 16'h0000, 16'h0020, 16'h0000, 4'd8, 0, 0, 1);
    add(0, 0, 16'h0000, 16'h0020, 16'h0000, 4'd8, 0, 0, 0);

    // Reset during SERVE of 7; afterwards the search restarts at index 0.
    add(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 0);
    add(0, 0, 16'h0080, 16'h0080, 16'h0080, 4'd7, 0, 0, 1);
    add(0, 0, 16'h0080, 16'h0080, 16'h0080, 4'd7, 1, 1, 1);
    add(1, 0, 16'h0080, 16'h0080, 16'h0000, 4'd0, 0, 0, 0);
    add(0, 0, 16'hFFFF, 16'h0080, 16'h0001, 4'd0, 0, 0, 1);
    add(0, 0, 16'hFFFF, 16'h0080, 16'h0001, 4'd0, 1, 0, 1);
    add(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // All requesting: grants 0..15 then 0, six cycles apart, four valid cycles each.
    dpat = 16'hA5C3;
    for (int g = 0; g <= 16; g++) begin
      ix = 4'(g);
      run(0, 0, 16'hFFFF, dpat, 16'h0001 << ix, ix, 0, 0, 1);
      for (int c = 0; c < 3; c++) run(0, 0, 16'hFFFF, dpat, 16'h0001 << ix, ix, 1, dpat[ix], 1);
      run(0, 0, 16'hFFFF, dpat, 16'h0000, ix, 1, dpat[ix], 1);
      run(0, 0, 16'hFFFF, dpat, 16'h0000, ix, 0, 0, 0);
    end

`ifdef MUX16_RR_SCHED_LOCK_EN
    // Lock held: ten served cycles, ended only by the request drop.
    run(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 0, 0, 0);
    run(0, 1, 16'h0008, 16'h0008, 16'h0008, 4'd3, 0, 0, 1);
    for (int c = 0; c < 10; c++) run(0, 1, 16'h0008, 16'h0008, 16'h0008, 4'd3, 1, 1, 1);
    run(0, 1, 16'h0000, 16'h0008, 16'h0000, 4'd3, 0, 0, 1);
    run(0, 0, 16'h0000, 16'h0008, 16'h0000, 4'd3, 0, 0, 0);
`endif

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
